// File: rtl/calc_pkg.sv
// Shared definitions for the calculator front end: instruction width, opcodes,
// scheduler source/state encodings and small arithmetic helpers.
package calc_pkg;

    localparam int INST_W = 8;

    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_MULT = 2'b10;
    localparam logic [1:0] OP_SEND = 2'b11;

    typedef enum logic {
        SRC_MAN  = 1'b0,
        SRC_HOST = 1'b1
    } src_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_TX = 2'd2
    } state_e;

    function automatic logic is_send(input logic [1:0] op);
        return (op == OP_SEND);
    endfunction

    // Adds 0..2 rejected instructions to an 8-bit counter, pinning at 255.
    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {7'd0, b};
        if (sum[8]) begin
            return 8'hFF;
        end else begin
            return sum[7:0];
        end
    endfunction

endpackage

// File: rtl/inst_sched_if.sv
// Handshake bundle between the instruction sources, the scheduler and the datapath.
// With INST_SCHED_STATS_EN defined it also carries the per-source issue counters.
interface inst_sched_if;
    import calc_pkg::*;

    logic              man_vld;
    logic [INST_W-1:0] man_inst;
    logic              host_vld;
    logic [INST_W-1:0] host_inst;
    logic              host_rdy;
    logic              tx_busy;
    logic              inst_vld;
    logic [INST_W-1:0] inst_wd;
    logic [7:0]        drop_cnt;
    logic              tx_err;
`ifdef INST_SCHED_STATS_EN
    logic [15:0]       man_issue_cnt;
    logic [15:0]       host_issue_cnt;

    modport master (
        output man_vld, man_inst, host_vld, host_inst, tx_busy,
        input  host_rdy, inst_vld, inst_wd, drop_cnt, tx_err,
        input  man_issue_cnt, host_issue_cnt
    );

    modport slave (
        input  man_vld, man_inst, host_vld, host_inst, tx_busy,
        output host_rdy, inst_vld, inst_wd, drop_cnt, tx_err,
        output man_issue_cnt, host_issue_cnt
    );
`else
    modport master (
        output man_vld, man_inst, host_vld, host_inst, tx_busy,
        input  host_rdy, inst_vld, inst_wd, drop_cnt, tx_err
    );

    modport slave (
        input  man_vld, man_inst, host_vld, host_inst, tx_busy,
        output host_rdy, inst_vld, inst_wd, drop_cnt, tx_err
    );
`endif

endinterface

// File: rtl/inst_fifo.sv
// Synchronous FIFO with power-of-two depth; pointers wrap naturally and
// full/empty derive from an explicit occupancy count.
module inst_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == CW'(0));
    assign count     = count_r;
    assign rdata     = mem_r[rd_ptr_r];
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;

    // Pointer and occupancy bookkeeping; simultaneous push and pop keep the count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= CW'(0);
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

endmodule

// File: rtl/inst_sched.sv
// Round-robin scheduler sharing the datapath issue port between manual and host
// sources, holding off while a SEND owns the UART. Option: INST_SCHED_STATS_EN.
module inst_sched
    import calc_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TX_TIMEOUT = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    inst_sched_if.slave bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int TW = $clog2(TX_TIMEOUT + 1);

    state_e            state_r;
    state_e            state_s;
    src_e              last_src_r;
    src_e              pick_s;
    logic              man_pend_r;
    logic [INST_W-1:0] man_wd_r;
    logic              inst_vld_r;
    logic [INST_W-1:0] inst_wd_r;
    logic [7:0]        drop_cnt_r;
    logic              tx_err_r;
    logic              seen_busy_r;
    logic [TW-1:0]     timer_r;

    logic              fifo_push_s;
    logic              fifo_pop_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [INST_W-1:0] fifo_rdata_s;
    logic [CW-1:0]     fifo_count_s;
    logic              host_rdy_s;
    logic              man_drop_s;
    logic              host_drop_s;
    logic              grant_s;
    logic [INST_W-1:0] grant_wd_s;
    logic              tout_s;

    inst_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (INST_W)
    ) u_host_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push_s),
        .pop   (fifo_pop_s),
        .wdata (bus.host_inst),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    assign host_rdy_s  = (fifo_count_s != CW'(FIFO_DEPTH));
    assign fifo_push_s = bus.host_vld && !fifo_full_s;
    assign fifo_pop_s  = grant_s && (pick_s == SRC_HOST);
    assign man_drop_s  = bus.man_vld && man_pend_r;
    assign host_drop_s = bus.host_vld && !host_rdy_s;

    // Arbitration: alternate when both sources wait; a blocked SEND stalls both.
    always_comb begin
        pick_s     = SRC_MAN;
        grant_wd_s = man_wd_r;
        grant_s    = 1'b0;
        if (man_pend_r && !fifo_empty_s) begin
            if (last_src_r == SRC_MAN) begin
                pick_s = SRC_HOST;
            end else begin
                pick_s = SRC_MAN;
            end
        end else if (!fifo_empty_s) begin
            pick_s = SRC_HOST;
        end else begin
            pick_s = SRC_MAN;
        end
        if (pick_s == SRC_HOST) begin
            grant_wd_s = fifo_rdata_s;
        end else begin
            grant_wd_s = man_wd_r;
        end
        if ((state_r == IDLE) && (man_pend_r || !fifo_empty_s) &&
            !(is_send(grant_wd_s[INST_W-1 -: 2]) && bus.tx_busy)) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    // Next-state logic; WAIT_TX needs a busy pulse to finish, or the timer expires.
    always_comb begin
        state_s = state_r;
        tout_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (grant_s) begin
                    state_s = ISSUE;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                if (is_send(inst_wd_r[INST_W-1 -: 2])) begin
                    state_s = WAIT_TX;
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT_TX: begin
                if (seen_busy_r && !bus.tx_busy) begin
                    state_s = IDLE;
                end else if (timer_r == TW'(TX_TIMEOUT - 1)) begin
                    state_s = IDLE;
                    tout_s  = 1'b1;
                end else begin
                    state_s = WAIT_TX;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Transmitter watch: armed in ISSUE, then counts cycles and remembers busy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            timer_r     <= TW'(0);
            seen_busy_r <= 1'b0;
        end else if (state_r == ISSUE) begin
            timer_r     <= TW'(0);
            seen_busy_r <= 1'b0;
        end else if (state_r == WAIT_TX) begin
            timer_r     <= timer_r + TW'(1);
            seen_busy_r <= seen_busy_r | bus.tx_busy;
        end else begin
            timer_r     <= timer_r;
            seen_busy_r <= seen_busy_r;
        end
    end

    // Issue port; inst_wd keeps the last issued word between grants.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inst_vld_r <= 1'b0;
            inst_wd_r  <= {INST_W{1'b0}};
            last_src_r <= SRC_HOST;
        end else if (grant_s) begin
            inst_vld_r <= 1'b1;
            inst_wd_r  <= grant_wd_s;
            last_src_r <= pick_s;
        end else begin
            inst_vld_r <= 1'b0;
            inst_wd_r  <= inst_wd_r;
            last_src_r <= last_src_r;
        end
    end

    // Single-entry manual holding register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            man_pend_r <= 1'b0;
            man_wd_r   <= {INST_W{1'b0}};
        end else if (grant_s && (pick_s == SRC_MAN)) begin
            man_pend_r <= 1'b0;
            man_wd_r   <= man_wd_r;
        end else if (bus.man_vld && !man_pend_r) begin
            man_pend_r <= 1'b1;
            man_wd_r   <= bus.man_inst;
        end else begin
            man_pend_r <= man_pend_r;
            man_wd_r   <= man_wd_r;
        end
    end

    // Error reporting: saturating drop count and sticky transmit timeout.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_cnt_r <= 8'd0;
            tx_err_r   <= 1'b0;
        end else begin
            drop_cnt_r <= sat_add8(drop_cnt_r, {1'b0, man_drop_s} + {1'b0, host_drop_s});
            tx_err_r   <= tx_err_r | tout_s;
        end
    end

    assign bus.host_rdy = host_rdy_s;
    assign bus.inst_vld = inst_vld_r;
    assign bus.inst_wd  = inst_wd_r;
    assign bus.drop_cnt = drop_cnt_r;
    assign bus.tx_err   = tx_err_r;

`ifdef INST_SCHED_STATS_EN
    logic [15:0] man_issue_cnt_r;
    logic [15:0] host_issue_cnt_r;

    // Per-source issue counters, bumped once per ISSUE cycle and wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            man_issue_cnt_r  <= 16'd0;
            host_issue_cnt_r <= 16'd0;
        end else if (inst_vld_r && (last_src_r == SRC_MAN)) begin
            man_issue_cnt_r  <= man_issue_cnt_r + 16'd1;
            host_issue_cnt_r <= host_issue_cnt_r;
        end else if (inst_vld_r) begin
            man_issue_cnt_r  <= man_issue_cnt_r;
            host_issue_cnt_r <= host_issue_cnt_r + 16'd1;
        end else begin
            man_issue_cnt_r  <= man_issue_cnt_r;
            host_issue_cnt_r <= host_issue_cnt_r;
        end
    end

    assign bus.man_issue_cnt  = man_issue_cnt_r;
    assign bus.host_issue_cnt = host_issue_cnt_r;
`endif

endmodule

// File: tb/tb_inst_sched.sv
// Bench for inst_sched: queue-based reference model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic.
module tb_inst_sched;
    localparam int DEPTH = 4;
    localparam int TOUT  = 4096;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    inst_sched_if bus();

    inst_sched #(.FIFO_DEPTH(DEPTH), .TX_TIMEOUT(TOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state
    bit [7:0] m_q[$];
    bit       m_pend      = 1'b0;
    bit [7:0] m_man       = 8'h00;
    bit       m_last_host = 1'b1;
    int       m_phase     = 0;   // 0 free to issue, 1 issuing, 2 waiting on transmitter
    int       m_wait      = 0;
    bit       m_seen      = 1'b0;
    bit       m_vld       = 1'b0;
    bit [7:0] m_wd        = 8'h00;
    int       m_drop      = 0;
    bit       m_err       = 1'b0;
    bit       m_from_host = 1'b0;
    int       m_man_cnt   = 0;
    int       m_host_cnt  = 0;

    int       log_cyc[$];
    bit [7:0] log_wd[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_step();
        bit       mdrop;
        bit       hdrop;
        bit       was_full;
        bit       from_host;
        bit       vld_next;
        bit [7:0] w;
        if (!rst_n) begin
            m_q.delete();
            m_pend = 1'b0; m_last_host = 1'b1; m_phase = 0; m_vld = 1'b0; m_wd = 8'h00;
            m_drop = 0; m_err = 1'b0; m_man_cnt = 0; m_host_cnt = 0;
            return;
        end
        if (m_vld) begin
            if (m_from_host) m_host_cnt = (m_host_cnt + 1) % 65536;
            else             m_man_cnt  = (m_man_cnt + 1) % 65536;
        end
        mdrop    = bus.man_vld && m_pend;
        was_full = (m_q.size() == DEPTH);
        hdrop    = bus.host_vld && was_full;
        vld_next = 1'b0;
        if (m_phase == 0) begin
            if (m_pend || m_q.size() > 0) begin
                if (m_pend && m_q.size() > 0) from_host = !m_last_host;
                else                          from_host = (m_q.size() > 0);
                w = from_host ? m_q[0] : m_man;
                if (!(w[7:6] == 2'b11 && bus.tx_busy)) begin
                    m_wd = w; m_last_host = from_host; m_from_host = from_host;
                    if (from_host) void'(m_q.pop_front());
                    else           m_pend = 1'b0;
                    vld_next = 1'b1;
                    m_phase  = 1;
                end
            end
        end else if (m_phase == 1) begin
            m_phase = (m_wd[7:6] == 2'b11) ? 2 : 0;
            m_wait  = 0;
            m_seen  = 1'b0;
        end else begin
            m_wait++;
            if (m_seen && !bus.tx_busy) m_phase = 0;
            else if (m_wait == TOUT) begin m_err = 1'b1; m_phase = 0; end
            else if (bus.tx_busy) m_seen = 1'b1;
        end
        m_vld = vld_next;
        if (bus.man_vld && !mdrop) begin m_pend = 1'b1; m_man = bus.man_inst; end
        if (bus.host_vld && !was_full) m_q.push_back(bus.host_inst);
        m_drop = m_drop + int'(mdrop) + int'(hdrop);
        if (m_drop > 255) m_drop = 255;
    endtask

    // Advance the model on each edge, then compare all outputs once they settle.
    always @(posedge clk) begin
        model_step();
        cyc++;
        #2;
        chk("inst_vld", bus.inst_vld, m_vld);
        chk("inst_wd",  bus.inst_wd,  m_wd);
        chk("drop_cnt", bus.drop_cnt, m_drop);
        chk("tx_err",   bus.tx_err,   m_err);
        chk("host_rdy", bus.host_rdy, m_q.size() != DEPTH);
`ifdef INST_SCHED_STATS_EN
        chk("man_issue_cnt",  bus.man_issue_cnt,  m_man_cnt);
        chk("host_issue_cnt", bus.host_issue_cnt, m_host_cnt);
`endif
        if (bus.inst_vld === 1'b1) begin
            log_cyc.push_back(cyc);
            log_wd.push_back(bus.inst_wd);
        end
    end

    task automatic wait_log(input int n, input int budget, output bit ok);
        int k = 0;
        while (log_wd.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        ok = (log_wd.size() >= n);
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL wait_issue: got %0d issues, expected %0d", log_wd.size(), n);
        end
    endtask

    task automatic wait_cyc(input int k);
        while (cyc < k) @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic idle_inputs();
        bus.man_vld = 1'b0; bus.host_vld = 1'b0;
        bus.man_inst = 8'h00; bus.host_inst = 8'h00;
    endtask

    initial begin
        bit       ok;
        int       base;
        int       t0;
        int       ti;
        bit [7:0] hb[5];
        bit [7:0] ord[4];
        hb  = '{8'h11, 8'h52, 8'h93, 8'h24, 8'h35};
        ord = '{8'h00, 8'h13, 8'h82, 8'h23};
        idle_inputs();
        bus.tx_busy = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_inst_vld", bus.inst_vld, 1'b0);
        chk("rst_host_rdy", bus.host_rdy, 1'b1);
        chk("rst_drop_cnt", bus.drop_cnt, 8'd0);
        rst_n = 1'b1;

        // Manual PUSH latency
        @(negedge clk);
        t0 = cyc; base = log_wd.size();
        bus.man_vld = 1'b1; bus.man_inst = 8'h04;
        @(negedge clk);
        idle_inputs();
        wait_log(base + 1, 20, ok);
        if (ok) begin
            chk("t1_word", log_wd[base], 8'h04);
            chk("t1_latency", log_cyc[base] - t0, 2);
        end
        chk("t1_host_rdy", bus.host_rdy, 1'b1);

        // Round-robin order after reset, manual first
        pulse_reset();
        @(negedge clk);
        base = log_wd.size();
        bus.man_vld = 1'b1; bus.man_inst = 8'h00; bus.host_vld = 1'b1; bus.host_inst = 8'h13;
        @(negedge clk); bus.man_vld = 1'b0; bus.host_inst = 8'h82;
        @(negedge clk); bus.host_inst = 8'h23;
        @(negedge clk); idle_inputs();
        wait_log(base + 4, 30, ok);
        if (ok) begin
            for (int i = 0; i < 4; i++) chk("t2_order", log_wd[base + i], ord[i]);
            for (int i = 1; i < 4; i++) chk("t2_spacing", log_cyc[base + i] - log_cyc[base + i - 1], 2);
        end

        // FIFO overflow while a SEND is stalled, then SEND timeout
        @(negedge clk);
        base = log_wd.size();
        bus.tx_busy = 1'b1; bus.man_vld = 1'b1; bus.man_inst = 8'hC0;
        @(negedge clk); idle_inputs();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 4) chk("t3_full_rdy", bus.host_rdy, 1'b0);
            bus.host_vld = 1'b1; bus.host_inst = hb[i];
        end
        @(negedge clk); idle_inputs();
        chk("t3_drop1", bus.drop_cnt, 8'd1);
        bus.man_vld = 1'b1; bus.man_inst = 8'h01;
        @(negedge clk); idle_inputs();
        @(negedge clk);
        chk("t3_drop2", bus.drop_cnt, 8'd2);
        chk("t3_stalled", log_wd.size() - base, 0);
        bus.tx_busy = 1'b0;
        wait_log(base + 1, 20, ok);
        if (ok) chk("t3_send", log_wd[base], 8'hC0);
        wait_log(base + 2, TOUT + 40, ok);
        if (ok) begin
            chk("t5_next_word", log_wd[base + 1], 8'h11);
            chk("t5_timeout_gap", log_cyc[base + 1] - log_cyc[base], TOUT + 2);
            chk("t5_tx_err", bus.tx_err, 1'b1);
        end
        wait_log(base + 5, 30, ok);
        if (ok) for (int i = 2; i < 5; i++) chk("t3_drain", log_wd[base + i], hb[i - 1]);

        // SEND with a proper busy pulse
        pulse_reset();
        @(negedge clk);
        base = log_wd.size();
        bus.man_vld = 1'b1; bus.man_inst = 8'hC0; bus.host_vld = 1'b1; bus.host_inst = 8'h04;
        @(negedge clk); idle_inputs();
        wait_log(base + 1, 20, ok);
        if (ok) begin
            chk("t4_send", log_wd[base], 8'hC0);
            ti = log_cyc[base];
            wait_cyc(ti + 3);   bus.tx_busy = 1'b1;
            wait_cyc(ti + 103); bus.tx_busy = 1'b0;
            wait_log(base + 2, 200, ok);
            if (ok) begin
                chk("t4_word", log_wd[base + 1], 8'h04);
                chk("t4_release", log_cyc[base + 1] - ti, 105);
            end
            chk("t4_tx_err", bus.tx_err, 1'b0);
        end

        // Reset while waiting on the transmitter with three queued entries
        @(negedge clk);
        bus.man_vld = 1'b1; bus.man_inst = 8'hC0; bus.host_vld = 1'b1; bus.host_inst = 8'h01;
        @(negedge clk); bus.man_inst = 8'h05; bus.host_inst = 8'h02;
        @(negedge clk); bus.man_vld = 1'b0; bus.host_inst = 8'h03;
        @(negedge clk); idle_inputs();
        repeat (3) @(negedge clk);
        chk("t6_pre_drop", bus.drop_cnt, 8'd1);
        rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        chk("t6_host_rdy", bus.host_rdy, 1'b1);
        chk("t6_drop", bus.drop_cnt, 8'd0);
        chk("t6_inst_vld", bus.inst_vld, 1'b0);
        base = log_wd.size();
        repeat (6) @(negedge clk);
        chk("t6_no_issue", log_wd.size() - base, 0);

        // Drop counter saturation
        bus.tx_busy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            bus.man_vld = 1'b1; bus.man_inst = 8'hC0;
            bus.host_vld = 1'b1; bus.host_inst = 8'(i);
        end
        @(negedge clk); idle_inputs();
        chk("sat_drop", bus.drop_cnt, 8'd255);
        bus.tx_busy = 1'b0;
        pulse_reset();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            bus.man_vld   = ($urandom_range(0, 3) == 0);
            bus.man_inst  = 8'($urandom);
            bus.host_vld  = ($urandom_range(0, 2) == 0);
            bus.host_inst = 8'($urandom);
            if ($urandom_range(0, 7) == 0) bus.tx_busy = ~bus.tx_busy;
            rst_n = ($urandom_range(0, 599) != 0);
        end
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        bus.tx_busy = 1'b0;
        repeat (20) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_sched.md
Name: inst_sched

Overview:
- Instruction scheduler in front of the calculator datapath (PUSH/ADD/MULT/SEND ISA).
- Shares the datapath's single issue port between two requesters: the manual source (switches plus the debounced execute button) and the host source (instruction bytes from UART RX, buffered in a small FIFO).
- Issues one instruction at a time and holds off further issue while a SEND occupies the UART transmitter.

Parameters:
- FIFO_DEPTH, 4, host instruction FIFO entries; power of two, minimum 2.
- TX_TIMEOUT, 4096, cycles WAIT_TX waits for the transmitter before aborting.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- man_vld  in  1  one-cycle pulse: manual instruction present
- man_inst  in  8  manual instruction word (switch value)
- host_vld  in  1  one-cycle pulse: host instruction byte present
- host_inst  in  8  host instruction byte
- host_rdy  out  1  FIFO not full
- tx_busy  in  1  UART transmitter busy
- inst_vld  out  1  one-cycle issue strobe to datapath
- inst_wd  out  8  issued instruction word
- drop_cnt  out  8  saturating count of rejected instructions
- tx_err  out  1  sticky: SEND timed out

Behaviour:
- Clocking/reset: one clock, clk; reset is synchronous, active-low (rst_n).
- Reset values: inst_vld=0, inst_wd=0, drop_cnt=0, tx_err=0. FIFO is emptied, so host_rdy=1. man_pend=0, last_src=HOST, state=IDLE.
- Reset mid-operation aborts any WAIT_TX and discards FIFO contents and the pending manual instruction.
- Opcode is inst[7:6]: 00 PUSH, 01 ADD, 10 MULT, 11 SEND.
- Manual capture:
  - man_vld with man_pend=0 registers man_inst and sets man_pend.
  - man_vld with man_pend=1 is dropped; drop_cnt increments.
- Host capture:
  - host_rdy = (count != FIFO_DEPTH), combinational from occupancy only.
  - host_vld && host_rdy writes the FIFO.
  - host_vld while full is dropped; drop_cnt increments. This applies even if a pop occurs in the same cycle.
  - Push and pop in the same cycle leave count unchanged. Pointers wrap modulo FIFO_DEPTH.
- drop_cnt saturates at 255. A manual drop and a host drop in the same cycle add 2, saturating.
- State IDLE:
  - Candidates are man_pend and FIFO non-empty.
  - If both are present, grant the source other than last_src (round-robin). Otherwise grant the one present.
  - If the granted word is SEND and tx_busy=1: no grant, no rotation, remain IDLE. The other source may not bypass.
  - On grant: latch inst_wd, pop/clear the source, update last_src, go to ISSUE.
- State ISSUE: inst_vld=1 for exactly this cycle. Then go to WAIT_TX if the opcode is SEND, else IDLE.
- State WAIT_TX:
  - Wait for tx_busy to go high, then low, then go to IDLE.
  - If TX_TIMEOUT cycles pass in WAIT_TX without that sequence completing, set tx_err and go to IDLE.
- Latency: man_vld at cycle N gives man_pend at N+1, grant at N+1, inst_vld at N+2. Host latency is the same when the FIFO is empty.
- Throughput: one non-SEND instruction every 2 cycles.
- inst_wd holds its last issued value between issues.

Optional Feature:
- INST_SCHED_STATS_EN defined: adds outputs man_issue_cnt[15:0] and host_issue_cnt[15:0]. Each increments on every ISSUE cycle of its source, wraps at 65535, and resets to 0.
- Macro undefined: these ports and counters do not exist. All other behaviour is identical.

Decomposition:
- Shared package calc_pkg holds:
  - INST_W=8
  - opcode constants OP_PUSH/OP_ADD/OP_MULT/OP_SEND
  - source enum SRC_MAN/SRC_HOST
  - state enum IDLE/ISSUE/WAIT_TX
- One sub-module: inst_fifo (parameterised synchronous FIFO with push/pop/full/empty/count), instantiated for the host path. Arbiter and FSM stay in inst_sched.

Test Plan:
- Reset, then man_vld with 0x04 (PUSH r0,4) -> inst_vld pulses at N+2 with inst_wd=0x04; host_rdy=1 throughout.
- Host pushes 0x13, 0x82, 0x23 while man_pend holds 0x00 -> issue order 0x00 (manual first after reset), 0x13, 0x82, 0x23, each inst_vld a single cycle.
- Host pushes 5 bytes back-to-back with the scheduler stalled on SEND (tx_busy=1) -> host_rdy=0 after the 4th byte, 5th dropped, drop_cnt=1; a second man_vld while pending -> drop_cnt=2.
- Issue SEND 0xC0; tx_busy high 3 cycles after inst_vld for 100 cycles, with 0x04 queued -> 0x04 not issued until the cycle after tx_busy falls plus 1; tx_err stays 0.
- SEND 0xC0 with tx_busy never asserting -> after TX_TIMEOUT cycles tx_err=1, scheduler returns to IDLE and issues the next queued word.
- Assert rst_n=0 for one cycle during WAIT_TX with 3 FIFO entries -> next cycle: state IDLE, FIFO empty, host_rdy=1, drop_cnt=0, no inst_vld.
